// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction constants and sizing helper for the counter slice
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((longint'(1) << bits) < longint'(value)) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides the enable stream by PRESCALE into a single-cycle tick
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_pass
            logic w_unused;
            assign w_unused = ^{clk, rst, clr};
            assign tick     = en;
        end else begin : g_div
            localparam int LP_PW = clog2(PRESCALE);
            localparam logic [LP_PW-1:0] LP_LAST = LP_PW'(PRESCALE - 1);

            logic [LP_PW-1:0] r_p;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_p <= '0;
                end else if (en) begin
                    r_p <= (r_p == LP_LAST) ? '0 : r_p + LP_PW'(1);
                end
            end

            assign tick = en && (r_p == LP_LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - up/down modulo counter with prescaler, load, tc and wrap; COUNTER_SAT_EN selects saturating mode
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam int LP_W = WIDTH + 1;
    localparam logic [WIDTH:0] LP_MAX = LP_W'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "counter_updown_mod: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
            $fatal(1, "counter_updown_mod: MODULUS must be 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $fatal(1, "counter_updown_mod: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_tick;
    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_load_clamped;
    logic [WIDTH:0]   w_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_roll;
    logic             w_unused;

    // Load clears the prescaler so the loaded value gets a full step period.
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (en),
        .tick(w_tick)
    );

    assign w_cur          = {1'b0, r_count};
    assign w_load_ext     = {1'b0, load_val};
    assign w_load_clamped = (w_load_ext > LP_MAX) ? LP_MAX : w_load_ext;
    assign w_at_max       = (w_cur == LP_MAX);
    assign w_at_zero      = (w_cur == '0);

    always_comb begin
        w_next = w_cur;
        w_roll = 1'b0;
        if (up == DIR_UP) begin
`ifdef COUNTER_SAT_EN
            w_next = w_at_max ? LP_MAX : w_cur + LP_W'(1);
`else
            w_next = w_at_max ? '0 : w_cur + LP_W'(1);
            w_roll = w_at_max;
`endif
        end else begin
`ifdef COUNTER_SAT_EN
            w_next = w_at_zero ? '0 : w_cur - LP_W'(1);
`else
            w_next = w_at_zero ? LP_MAX : w_cur - LP_W'(1);
            w_roll = w_at_zero;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped[WIDTH-1:0];
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_next[WIDTH-1:0];
            r_wrap  <= w_roll;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    // Top bits are always zero because every candidate value is <= LP_MAX.
    assign w_unused = ^{w_next[WIDTH], w_load_clamped[WIDTH]};

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = (up == DIR_UP) ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed bench for counter_updown_mod in default or COUNTER_SAT_EN builds
module tb_counter_updown_mod;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [2:0] load_val;
    logic [2:0] c8, c5, c53;
    logic       tc8, tc5, tc53, w8, w5, w53;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c8), .tc(tc8), .wrap(w8));

    counter_updown_mod #(.WIDTH(3), .MODULUS(5), .PRESCALE(1)) u5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c5), .tc(tc5), .wrap(w5));

    counter_updown_mod #(.WIDTH(3), .MODULUS(5), .PRESCALE(3)) u53 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c53), .tc(tc53), .wrap(w53));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_wrap();
        int ec;
        bit ew;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 3'd0;
        repeat (10) cyc();
        checks++;
        if (c8 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", c8); end
        checks++;
        if (w8 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0d want 0", w8); end
        rst = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (tc8 !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0d want 0", tc8); end
        for (int i = 1; i <= 10; i++) begin
            cyc();
            ec = SAT ? ((i > 7) ? 7 : i) : (i % 8);
            ew = !SAT && (i == 8);
            checks++;
            if (c8 !== 3'(ec)) begin errors++; $display("FAIL up8_count[%0d]: got %0d want %0d", i, c8, ec); end
            checks++;
            if (w8 !== ew) begin errors++; $display("FAIL up8_wrap[%0d]: got %0d want %0d", i, w8, ew); end
            checks++;
            if (tc8 !== (ec == 7)) begin errors++; $display("FAIL up8_tc[%0d]: got %0d want %0d", i, tc8, ec == 7); end
        end
    endtask

    task automatic test_down_mod5();
        int exp_c [6];
        bit ew;
`ifdef COUNTER_SAT_EN
        exp_c = '{0, 0, 0, 0, 0, 0};
`else
        exp_c = '{4, 3, 2, 1, 0, 4};
`endif
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
        cyc();
        rst = 1'b0;
        checks++;
        if (tc5 !== 1'b1) begin errors++; $display("FAIL dn5_tc_init: got %0d want 1", tc5); end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            ew = !SAT && (i == 0 || i == 5);
            checks++;
            if (c5 !== 3'(exp_c[i])) begin errors++; $display("FAIL dn5_count[%0d]: got %0d want %0d", i, c5, exp_c[i]); end
            checks++;
            if (w5 !== ew) begin errors++; $display("FAIL dn5_wrap[%0d]: got %0d want %0d", i, w5, ew); end
            checks++;
            if (tc5 !== (exp_c[i] == 0)) begin errors++; $display("FAIL dn5_tc[%0d]: got %0d want %0d", i, tc5, exp_c[i] == 0); end
        end
    endtask

    task automatic test_prescale();
        bit en_seq [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        int exp_c  [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            en = en_seq[i];
            cyc();
            checks++;
            if (c53 !== 3'(exp_c[i])) begin errors++; $display("FAIL pre3_count[%0d]: got %0d want %0d", i, c53, exp_c[i]); end
        end
        checks++;
        if (w53 !== 1'b0) begin errors++; $display("FAIL pre3_wrap: got %0d want 0", w53); end
    endtask

    task automatic test_load_priority();
        en = 1'b1; up = 1'b1;
        repeat (2) cyc();
        checks++;
        if (c53 !== 3'd3) begin errors++; $display("FAIL ld_pretick: got %0d want 3", c53); end
        load = 1'b1; load_val = 3'd6;
        cyc();
        checks++;
        if (c53 !== 3'd4) begin errors++; $display("FAIL ld_clamp: got %0d want 4", c53); end
        checks++;
        if (w53 !== 1'b0) begin errors++; $display("FAIL ld_wrap: got %0d want 0", w53); end
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (c53 !== 3'd4) begin errors++; $display("FAIL ld_pclr[%0d]: got %0d want 4", i, c53); end
        end
        cyc();
        checks++;
        if (c53 !== (SAT ? 3'd4 : 3'd0)) begin errors++; $display("FAIL ld_step: got %0d want %0d", c53, SAT ? 4 : 0); end
        checks++;
        if (w53 !== !SAT) begin errors++; $display("FAIL ld_step_wrap: got %0d want %0d", w53, !SAT); end
        rst = 1'b1; load = 1'b1; load_val = 3'd2;
        cyc();
        checks++;
        if (c53 !== 3'd0) begin errors++; $display("FAIL ld_vs_rst: got %0d want 0", c53); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (c53 !== 3'd2) begin errors++; $display("FAIL ld_hold[%0d]: got %0d want 2", i, c53); end
        end
        load = 1'b0;
    endtask

    task automatic test_dir_flip();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        cyc();
        rst = 1'b0; load = 1'b1; load_val = 3'd3;
        cyc();
        load = 1'b0; up = 1'b0; en = 1'b1;
        cyc();
        checks++;
        if (c8 !== 3'd2) begin errors++; $display("FAIL flip_down: got %0d want 2", c8); end
        up = 1'b1;
        cyc();
        checks++;
        if (c8 !== 3'd3) begin errors++; $display("FAIL flip_up: got %0d want 3", c8); end
        en = 1'b0; load = 1'b1; load_val = 3'd7;
        cyc();
        load = 1'b0;
        checks++;
        if (c5 !== 3'd4) begin errors++; $display("FAIL flip_clamp5: got %0d want 4", c5); end
        up = 1'b1; #1;
        checks++;
        if (tc8 !== 1'b1) begin errors++; $display("FAIL tc_up8: got %0d want 1", tc8); end
        checks++;
        if (tc5 !== 1'b1) begin errors++; $display("FAIL tc_up5: got %0d want 1", tc5); end
        up = 1'b0; #1;
        checks++;
        if (tc8 !== 1'b0) begin errors++; $display("FAIL tc_dn8: got %0d want 0", tc8); end
        checks++;
        if (tc5 !== 1'b0) begin errors++; $display("FAIL tc_dn5: got %0d want 0", tc5); end
    endtask

    task automatic test_saturate();
        int ec;
        bit ew;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        cyc();
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            ec = SAT ? ((i > 7) ? 7 : i) : (i % 8);
            ew = !SAT && (i == 8);
            checks++;
            if (c8 !== 3'(ec)) begin errors++; $display("FAIL sat_up[%0d]: got %0d want %0d", i, c8, ec); end
            checks++;
            if (w8 !== ew) begin errors++; $display("FAIL sat_up_wrap[%0d]: got %0d want %0d", i, w8, ew); end
        end
        checks++;
        if (tc8 !== SAT) begin errors++; $display("FAIL sat_tc: got %0d want %0d", tc8, SAT); end
        up = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            ec = SAT ? ((7 - i < 0) ? 0 : 7 - i) : ((4 - i + 8) % 8);
            ew = !SAT && (i == 5);
            checks++;
            if (c8 !== 3'(ec)) begin errors++; $display("FAIL sat_dn[%0d]: got %0d want %0d", i, c8, ec); end
            checks++;
            if (w8 !== ew) begin errors++; $display("FAIL sat_dn_wrap[%0d]: got %0d want %0d", i, w8, ew); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 3'd0;
        test_reset_wrap();
        test_down_mod5();
        test_prescale();
        test_load_priority();
        test_dir_flip();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down modulo counter with clock-enable, prescaler, parallel load, terminal-count flag and wrap pulse. It replaces the fixed 3-bit free-running counter wherever the design needs a programmable range, direction control or a slower count rate, such as timers, sequencers and cascaded counter chains. The wrap output drives the enable of a following stage for cascading.

## Interface
- WIDTH, 3, count register width; 1..32
- MODULUS, 8, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
- PRESCALE, 1, enabled cycles per count step; >= 1
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; gates the prescaler
- up  input  1  direction: 1 increments, 0 decrements
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- count  output  WIDTH  registered count value
- tc  output  1  terminal count, combinational from count/up
- wrap  output  1  registered 1-cycle pulse on boundary crossing

## Operation
- Priority per clock edge: rst > load > step.
- rst=1: count=0, wrap=0, prescaler=0. No other input is sampled.
- load=1 (rst=0): count = min(load_val, MODULUS-1). Out-of-range values clamp to MODULUS-1. Prescaler clears to 0. wrap=0. en is ignored that cycle.
- Prescaler: internal counter p ranges 0..PRESCALE-1. It advances only when en=1. tick = en && (p == PRESCALE-1). On tick, p returns to 0. With PRESCALE=1, tick = en.
- Step on tick:
  - up=1: count = (count == MODULUS-1) ? 0 : count+1.
  - up=0: count = (count == 0) ? MODULUS-1 : count-1.
- wrap: set to 1 on the edge where count rolls over (MODULUS-1 to 0 up, 0 to MODULUS-1 down); 0 on every other edge.
- tc = up ? (count == MODULUS-1) : (count == 0). It is purely combinational and changes immediately with up.
- en=0: count, p and the direction-independent state hold. wrap drops to 0 on the next edge.
- A change of up between ticks takes effect on the next tick. The prescaler phase is not disturbed.
- Arithmetic is done in WIDTH+1 bits internally. count never holds a value >= MODULUS.

## Timing
- count and wrap are registered and update one edge after the sampled inputs.
- Latency: load to count is 1 cycle. A tick changes count on the same edge that tick is sampled.
- wrap is high for exactly one cycle, coincident with the first cycle count shows its post-roll value.
- Cascade rule: stage N+1 en = stage N wrap (with up=1). Stage N+1 then steps one cycle after stage N rolls over.
- Reset mid-count clears everything on the next edge. No partial prescaler state survives.
- load asserted continuously holds count at the clamped load_val, with p=0.

## Configuration
- COUNTER_SAT_EN defined: saturating mode.
  - The up-step at MODULUS-1 holds at MODULUS-1.
  - The down-step at 0 holds at 0.
  - wrap is tied to 0.
  - tc behaves as before, marking the saturated value.
- COUNTER_SAT_EN undefined (default): modulo wrap behaviour as described in Operation.

## Structure
- The shared package counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - the clog2 helper used to size the prescaler counter.
- One sub-module, counter_prescaler, with parameter PRESCALE and ports clk, rst, clr, en, tick. For PRESCALE=1 it degenerates to tick=en with no register.
- Parameter legality is checked at elaboration. Illegal MODULUS or PRESCALE values are a fatal elaboration error.

## Test plan
- Reset and wrap: WIDTH=3, MODULUS=8, PRESCALE=1. Hold rst for 10 cycles, then en=1, up=1 for 10 cycles.
  - Required: count 0,1,...,7,0,1.
  - wrap high only in the cycle count first reads 0 after 7.
  - tc high while count=7.
- Non-power-of-two range: MODULUS=5, up=0 from reset.
  - Required: count 0,4,3,2,1,0,4.
  - wrap pulses when count reads 4.
  - tc high at count=0.
- Prescale: PRESCALE=3, en=1 continuous.
  - Required: count steps every 3rd cycle.
  - Drop en for 2 cycles mid-phase: count and phase hold, and stepping resumes after the remaining enabled cycles.
- Load priority and clamp: MODULUS=5. Assert load with load_val=6, en=1 and a pending tick in the same cycle.
  - Required: count=4 and the prescaler clears.
  - Then load_val=2 together with rst: count=0.
- Direction flip: at count=3, toggle up between ticks.
  - Required: the next tick decrements to 2.
  - tc follows up combinationally in the same cycle.
- Saturate build (COUNTER_SAT_EN): MODULUS=8, up=1 for 12 ticks.
  - Required: count stops at 7, wrap stays 0, tc=1.
  - Then up=0 for 9 ticks: count stops at 0.
